// File: rtl/des_key_schedule_if.sv
// Request/response bundle between a DES key-schedule master and the schedule engine.
// Optional port decrypt exists only when DES_KEY_SCHEDULE_DECRYPT_EN is defined.
interface des_key_schedule_if;
  logic         start;
  logic [1:64]  key;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  logic         decrypt;
`endif
  logic         busy;
  logic         done;
  logic [1:768] round_keys;

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  modport master (output start, key, decrypt, input busy, done, round_keys);
  modport slave  (input start, key, decrypt, output busy, done, round_keys);
`else
  modport master (output start, key, input busy, done, round_keys);
  modport slave  (input start, key, output busy, done, round_keys);
`endif
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit round key per clock, packed K1..K16 into a 768-bit bus.
// Define DES_KEY_SCHEDULE_DECRYPT_EN to add the decrypt input (reverse key order).
module des_key_schedule (
  input  logic             clk,
  input  logic             rst_n,
  des_key_schedule_if.slave bus
);

  localparam int unsigned Pc1Table [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Table [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [1:0] {StIdle, StRound, StFinish} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:28]  c_q, c_d, d_q, d_d;
  logic [1:768] rk_q, rk_d;
  logic         dec_q, dec_d;
  logic         dec_in;
  logic         busy, done;

  logic [1:56]  pc1;
  logic [1:28]  c_rot, d_rot;
  logic [1:56]  cd_rot;
  logic [1:48]  k_i;
  logic         one_shift;

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  assign dec_in = bus.decrypt;
`else
  assign dec_in = 1'b0;
`endif

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1[i+1] = bus.key[Pc1Table[i]];
  end

  // Rounds 1, 2, 9 and 16 rotate by one; all others by two (28 bits total).
  assign one_shift = (cnt_q == 4'd0) || (cnt_q == 4'd1) || (cnt_q == 4'd8) || (cnt_q == 4'd15);
  assign c_rot     = one_shift ? {c_q[2:28], c_q[1]} : {c_q[3:28], c_q[1:2]};
  assign d_rot     = one_shift ? {d_q[2:28], d_q[1]} : {d_q[3:28], d_q[1:2]};
  assign cd_rot    = {c_rot, d_rot};

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign k_i[j+1] = cd_rot[Pc2Table[j]];
  end

  // Parity bits of the key and the eight C/D bits PC-2 drops are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{bus.key[8], bus.key[16], bus.key[24], bus.key[32], bus.key[40],
                         bus.key[48], bus.key[56], bus.key[64],
                         cd_rot[9], cd_rot[18], cd_rot[22], cd_rot[25],
                         cd_rot[35], cd_rot[38], cd_rot[43], cd_rot[54]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    d_d     = d_q;
    rk_d    = rk_q;
    dec_d   = dec_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          c_d     = pc1[1:28];
          d_d     = pc1[29:56];
          cnt_d   = 4'd0;
          dec_d   = dec_in;
          state_d = StRound;
        end
      end
      StRound: begin
        busy  = 1'b1;
        c_d   = c_rot;
        d_d   = d_rot;
        cnt_d = cnt_q + 4'd1;
        rk_d  = dec_q ? {k_i, rk_q[1:720]} : {rk_q[49:768], k_i};
        if (cnt_q == 4'd15) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      c_q     <= '0;
      d_q     <= '0;
      rk_q    <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      d_q     <= d_d;
      rk_q    <= rk_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.round_keys = rk_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: scoreboard of expected 768-bit key buses plus
// per-scenario latency/handshake checks.
module tb_des_key_schedule;

  localparam int Pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int Pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [1:64] KeyStd = 64'h1334_5779_9BBC_DFF1;
  localparam logic [1:64] KeyAlt = 64'h0E32_9232_EA6D_0D73;
  localparam logic [1:48] K1Std  = 48'h1B02_EFFC_7072;
  localparam logic [1:48] K2Std  = 48'h79AE_D9DB_C9E5;
  localparam logic [1:48] K16Std = 48'hCB3D_8B0E_17F5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [1:768] exp_q [$];

  always #5 clk = ~clk;

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference: rotate the PC-1 halves by the cumulative shift count for each round.
  function automatic logic [1:768] ref_schedule(input logic [1:64] k, input logic dec);
    logic [1:768] rk;
    logic [1:28]  c, d;
    logic [1:56]  cd;
    int           cum, slot;
    rk  = '0;
    cum = 0;
    for (int i = 0; i < 28; i++) begin
      c[i+1] = k[Pc1[i]];
      d[i+1] = k[Pc1[i+28]];
    end
    for (int r = 0; r < 16; r++) begin
      cum += Shifts[r];
      for (int j = 0; j < 28; j++) begin
        cd[j+1]  = c[(j + cum) % 28 + 1];
        cd[j+29] = d[(j + cum) % 28 + 1];
      end
      slot = dec ? 15 - r : r;
      for (int b = 0; b < 48; b++) rk[slot*48 + b + 1] = cd[Pc2[b]];
    end
    return rk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [1:64] k, input logic dec);
    bus.key   = k;
    bus.start = 1'b1;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    bus.decrypt = dec;
`else
    if (dec) $display("note: decrypt requested in encrypt-only build");
`endif
  endtask

  // Starts in the current cycle T and returns in cycle T+17 (the done cycle).
  task automatic run_schedule(input logic [1:64] k, input logic dec);
    drive_start(k, dec);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL busy_round cycle T+%0d busy=%b done=%b exp busy=1 done=0", c, bus.busy,
                 bus.done);
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_latency busy=%b done=%b exp busy=0 done=1", bus.busy, bus.done);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done got done=1 exp no done");
      end else begin
        logic [1:768] exp;
        exp = exp_q.pop_front();
        if (bus.round_keys !== exp) begin
          errors++;
          $display("FAIL sb_round_keys got %h exp %h", bus.round_keys, exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.key   = '0;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    bus.decrypt = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.round_keys !== '0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b rk_nonzero=%b exp 0 0 0", bus.busy, bus.done,
               |bus.round_keys);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_standard();
    exp_q.push_back(ref_schedule(KeyStd, 1'b0));
    run_schedule(KeyStd, 1'b0);
    checks++;
    if (bus.round_keys[1:48] !== K1Std) begin
      errors++;
      $display("FAIL std_k1 got %h exp %h", bus.round_keys[1:48], K1Std);
    end
    checks++;
    if (bus.round_keys[49:96] !== K2Std) begin
      errors++;
      $display("FAIL std_k2 got %h exp %h", bus.round_keys[49:96], K2Std);
    end
    checks++;
    if (bus.round_keys[721:768] !== K16Std) begin
      errors++;
      $display("FAIL std_k16 got %h exp %h", bus.round_keys[721:768], K16Std);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle got done=%b exp 0", bus.done);
    end
  endtask

  task automatic test_parity_keys();
    exp_q.push_back({768{1'b0}});
    run_schedule(64'h0101_0101_0101_0101, 1'b0);
    tick();
    exp_q.push_back({768{1'b1}});
    run_schedule(64'hFEFE_FEFE_FEFE_FEFE, 1'b0);
    tick();
  endtask

  task automatic test_ignore_start();
    exp_q.push_back(ref_schedule(KeyStd, 1'b0));
    drive_start(KeyStd, 1'b0);
    tick();
    for (int c = 1; c <= 17; c++) begin
      bus.start = (c == 3 || c == 10 || c == 17);
      bus.key   = bus.start ? KeyAlt : KeyStd;
      checks++;
      if (bus.busy !== (c <= 16) || bus.done !== (c == 17)) begin
        errors++;
        $display("FAIL ignore_start cycle T+%0d busy=%b done=%b exp busy=%b done=%b", c,
                 bus.busy, bus.done, c <= 16, c == 17);
      end
      tick();
    end
    bus.start = 1'b0;
    for (int c = 18; c <= 22; c++) begin
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL start_in_finish cycle T+%0d busy=%b exp 0", c, bus.busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(ref_schedule(KeyAlt, 1'b0));
    drive_start(KeyAlt, 1'b0);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.round_keys !== '0) begin
      errors++;
      $display("FAIL reset_mid busy=%b rk_nonzero=%b exp 0 0", bus.busy, |bus.round_keys);
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle done=%b busy=%b exp 0 0", bus.done, bus.busy);
      end
      tick();
    end
    exp_q.push_back(ref_schedule(KeyStd, 1'b0));
    run_schedule(KeyStd, 1'b0);
    checks++;
    if (bus.round_keys[1:48] !== K1Std || bus.round_keys[721:768] !== K16Std) begin
      errors++;
      $display("FAIL reset_mid_restart k1=%h k16=%h exp %h %h", bus.round_keys[1:48],
               bus.round_keys[721:768], K1Std, K16Std);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:768] exp1;
    exp1 = ref_schedule(KeyAlt, 1'b0);
    exp_q.push_back(exp1);
    run_schedule(KeyAlt, 1'b0);
    tick();
    checks++;
    if (bus.round_keys !== exp1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold busy=%b rk_match=%b exp 0 1", bus.busy, bus.round_keys === exp1);
    end
    exp_q.push_back(ref_schedule(KeyStd, 1'b0));
    run_schedule(KeyStd, 1'b0);
    tick();
    for (int n = 0; n < 4; n++) begin
      logic [1:64] k;
      k = {$urandom, $urandom};
      exp_q.push_back(ref_schedule(k, 1'b0));
      run_schedule(k, 1'b0);
      tick();
    end
  endtask

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  task automatic test_decrypt();
    exp_q.push_back(ref_schedule(KeyStd, 1'b1));
    run_schedule(KeyStd, 1'b1);
    checks++;
    if (bus.round_keys[1:48] !== K16Std || bus.round_keys[721:768] !== K1Std) begin
      errors++;
      $display("FAIL decrypt_order first=%h last=%h exp %h %h", bus.round_keys[1:48],
               bus.round_keys[721:768], K16Std, K1Std);
    end
    tick();
    bus.decrypt = 1'b0;
    exp_q.push_back(ref_schedule(KeyAlt, 1'b0));
    run_schedule(KeyAlt, 1'b0);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_standard();
    test_parity_keys();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    test_decrypt();
`endif
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Upstream stage of des_encryption: expands one 64-bit DES key into the 16 48-bit round keys and presents them as a single 768-bit bus for that block's round_keys input.
- Iterative: one round key per clock, using PC-1, per-round left rotations of C/D and PC-2.
- Key 1 sits at round_keys[1:48], so des_encryption can consume keys MSB-first by shifting left 48 bits per round.

Parameters:
- None. Widths are fixed by the DES standard.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  one-cycle request; key is valid in the same cycle
- key  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,...,64 ignored
- busy  output  1  high while a schedule is in progress
- done  output  1  one-cycle pulse; round_keys complete and valid
- round_keys  output  [1:768]  K1 at [1:48], K2 at [49:96], ..., K16 at [721:768]

Behaviour:
- Clock and reset: reset rst_n, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: state=IDLE, counter=0, C=D=0, round_keys=0, busy=0, done=0.
- Reset mid-operation: abandons the schedule, returns to IDLE and clears round_keys the same edge. No done pulse.
- FSM states: IDLE, ROUND, FINISH.
- IDLE:
  - busy=0.
  - start=1 loads {C,D} <= PC1(key) (C = 28 bits, D = 28 bits), clears counter, goes to ROUND.
  - start=0 holds state; round_keys keep their last value.
- ROUND:
  - busy=1.
  - Each cycle, round i = counter+1 rotates C and D left by s(i): s=1 for i in {1,2,9,16}, s=2 otherwise.
  - K_i = PC2({C_rot,D_rot}) from the rotated values (combinational).
  - round_keys <= {round_keys[49:768], K_i}. C,D <= rotated values. counter increments.
  - After the cycle with counter=15 (round 16), go to FINISH.
  - Total 16 ROUND cycles. Cumulative rotation is 28 bits, so C,D return to their PC1 values.
- FINISH:
  - done=1 for exactly one cycle, busy=0. Return to IDLE.
  - round_keys hold stable from this cycle until the next accepted start.
- Latency: start in cycle T -> done in cycle T+17. round_keys are final from cycle T+17.
- start while busy (ROUND) or in FINISH is ignored; the in-flight schedule is not disturbed.
- start in IDLE on the cycle right after done is accepted: back-to-back schedules, throughput 18 cycles.
- round_keys are not valid while busy; they show partial shifted contents.
- Counter is 4 bits and never wraps inside a schedule.

Optional Feature:
- Macro: DES_KEY_SCHEDULE_DECRYPT_EN.
- When defined:
  - Adds input port decrypt (1 bit), sampled together with start.
  - If decrypt=1: each K_i is inserted at the top, round_keys <= {K_i, round_keys[1:720]}. The final order is K16 at [1:48] ... K1 at [721:768], so des_encryption performs DES decryption unchanged.
  - If decrypt=0: identical to the base behaviour.
- When undefined: no decrypt port; encryption order only.

Test Plan:
- Standard vector: key=0x133457799BBCDFF1, start for 1 cycle -> done exactly 17 cycles later; round_keys[1:48]=0x1B02EFFC7072, round_keys[721:768]=0xCB3D8B0E17F5.
- Parity-only key: key=0x0101010101010101 -> all 768 bits 0. key=0xFEFEFEFEFEFEFEFE -> all 768 bits 1.
- start pulsed again at cycles T+3 and T+10 with a different key -> ignored; single done at T+17 with the original key's values; busy high in cycles T+1..T+16.
- rst_n low at T+8 -> next cycle busy=0 and round_keys=0; no done appears. A new start with 0x133457799BBCDFF1 afterwards gives the correct vector.
- Back-to-back: start at T+18 right after done at T+17 -> second done at T+35; round_keys stay stable and unchanged during cycle T+17.
- DES_KEY_SCHEDULE_DECRYPT_EN defined, decrypt=1, key 0x133457799BBCDFF1 -> round_keys[1:48]=0xCB3D8B0E17F5, round_keys[721:768]=0x1B02EFFC7072. Cross-check: feeding these keys to des_encryption with ciphertext 0x85E813540F0AB405 returns 0x0123456789ABCDEF.
